queue_fifo: RTL and testbench
=============================

Name: queue_fifo

Overview:
Circular-buffer queue storage and control stage for the Queue design. It accepts push/pop requests, holds up to DEPTH words, and produces a registered head word on each successful pop. The write-data select path (the 2:1 muxes) sits directly upstream and feeds data_i. Full, empty, count and error flags go to the surrounding queue logic.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 8, number of entries; must be a power of two, minimum 2
ADDR_WIDTH, 3, log2(DEPTH); pointer width

Ports:
clk_i  input  1  single clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
push_i  input  1  write request; data_i is captured when the push is accepted
pop_i  input  1  read request
data_i  input  DATA_WIDTH  word to enqueue
data_o  output  DATA_WIDTH  registered dequeued word
valid_o  output  1  one-cycle pulse; data_o is updated from an accepted pop
full_o  output  1  count == DEPTH
empty_o  output  1  count == 0
count_o  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow_o  output  1  one-cycle pulse; a push was rejected
underflow_o  output  1  one-cycle pulse; a pop was rejected

Behaviour:
- Reset (rst_i=1 at a rising edge) sets wr_ptr=0, rd_ptr=0, count=0.
- Reset also sets data_o=0, valid_o=0, overflow_o=0 and underflow_o=0, giving full_o=0 and empty_o=1.
- Reset does not clear storage contents.
- Reset has priority over push/pop in the same cycle. Reset mid-operation discards all queued data.
- full_o, empty_o and count_o are combinational decodes of the registered count and carry no extra latency.
- Acceptance is evaluated on the pre-edge state:
  - push_acc = push_i & (~full | pop_acc)
  - pop_acc = pop_i & ~empty
- Accepted push: mem[wr_ptr] <= data_i; wr_ptr <= wr_ptr+1, wrapping mod DEPTH with natural ADDR_WIDTH rollover.
- Accepted pop: data_o <= mem[rd_ptr] (the old contents, read before any same-edge write); rd_ptr <= rd_ptr+1 with wrap; valid_o <= 1.
- Pop latency: data_o and valid_o become valid on the edge that accepts the pop, i.e. visible the cycle after pop_i is sampled high. data_o holds its value until the next accepted pop.
- count update per edge:
  - +1 on push only
  - -1 on pop only
  - unchanged when both or neither are accepted
- Simultaneous push and pop:
  - Empty: the push is accepted and the pop is rejected (no bypass), so underflow_o pulses and count becomes 1.
  - Full: both are accepted and count stays DEPTH. The written slot is the one being vacated, and data_o receives its old value.
  - Otherwise: both are accepted and count is unchanged.
- Rejected push (push_i & full & ~pop_acc): storage, pointers and count are unchanged; overflow_o=1 for exactly one cycle.
- Rejected pop (pop_i & empty): pointers, count and data_o are unchanged; valid_o=0; underflow_o=1 for exactly one cycle.
- valid_o, overflow_o and underflow_o return to 0 on every edge where their condition is false.
- Ordering is strict FIFO across pointer wrap-around.
- Bench invariant: count never exceeds DEPTH and never drops below 0.

Test Plan:
- Reset, then fill: assert rst_i for 1 cycle, then push 0x11,0x22,...,0x88 on consecutive cycles -> count_o steps 1..8; full_o=1 after the 8th push; empty_o=0.
- Overflow: with the queue full, push 0x99 with no pop -> overflow_o pulses for 1 cycle; count_o stays 8; later draining yields no 0x99.
- Drain and underflow: pop 8 times -> data_o=0x11..0x88 in order, each with a valid_o pulse one cycle after pop_i; empty_o=1. A 9th pop -> underflow_o pulses, valid_o=0, data_o holds 0x88.
- Wrap-around: push 6 / pop 6, then push 0xA0..0xA5 and pop all -> output is 0xA0..0xA5 in order, with pointers having wrapped past entry 7.
- Simultaneous push and pop:
  - Empty queue, push 0x5A with pop -> underflow_o=1, count_o=1; a later pop returns 0x5A.
  - Full queue (0x11..0x88), push 0xC3 with pop -> data_o=0x11, count_o=8; the final pop of a full drain returns 0xC3.
- Reset mid-operation: with 5 entries queued, assert rst_i together with push_i and pop_i -> next cycle count_o=0, empty_o=1, data_o=0, valid_o=0, no flags raised; a following push/pop round-trips correctly.

Source files
------------

// File: rtl/queue_fifo.sv
// -----------------------------------------------------------------------------
// queue_fifo
//   Circular-buffer storage and control for the Queue design. Accepts push and
//   pop requests, holds up to DEPTH words and returns the head word through a
//   registered output on every accepted pop. Occupancy flags are decoded
//   combinationally from the registered count, so they carry no extra latency.
//
// Ports
//   clk_i        rising-edge clock for all state
//   rst_i        synchronous, active-high reset (wins over push/pop)
//   push_i       write request; data_i is captured when the push is accepted
//   pop_i        read request
//   data_i       word to enqueue
//   data_o       registered dequeued word, held until the next accepted pop
//   valid_o      one-cycle pulse: data_o was updated by an accepted pop
//   full_o       count == DEPTH
//   empty_o      count == 0
//   count_o      occupancy, 0..DEPTH
//   overflow_o   one-cycle pulse: a push was rejected
//   underflow_o  one-cycle pulse: a pop was rejected
// -----------------------------------------------------------------------------
module queue_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,   // power of two, minimum 2
  parameter int ADDR_WIDTH = 3    // log2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Storage
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Registered state and its next-state values
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  // Decodes of the pre-edge state
  logic full, empty;
  logic push_acc, pop_acc;
  logic mem_we;

  always_comb begin
    full  = (count_q == DEPTH_CNT);
    empty = (count_q == '0);

    // A pop frees a slot on the same edge, so a full queue still takes a push
    // when a pop is accepted alongside it. An empty queue never bypasses.
    pop_acc  = pop_i & ~empty;
    push_acc = push_i & (~full | pop_acc);

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;

    if (rst_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      data_d   = '0;
    end else begin
      if (push_acc) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);  // natural rollover wraps mod DEPTH
      end

      if (pop_acc) begin
        // Combinational read of the pre-edge contents: on a full push+pop the
        // slot being overwritten still returns its old word here.
        data_d   = mem[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        valid_d  = 1'b1;
      end

      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      overflow_d  = push_i & ~push_acc;
      underflow_d = pop_i & ~pop_acc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    count_q     <= count_d;
    data_q      <= data_d;
    valid_q     <= valid_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the pointers
  // and count, so stale words are never observable and the array can map onto
  // plain RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_queue_fifo.sv
// -----------------------------------------------------------------------------
// tb_queue_fifo
//   Directed bench for queue_fifo. Stimulus tasks drive requests, check the
//   per-cycle flags/count, and push the hand-computed expected pop words into a
//   scoreboard queue. An independent monitor on the falling edge pops and
//   compares whenever the DUT presents valid_o.
// -----------------------------------------------------------------------------
module tb_queue_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          push_i = 1'b0;
  logic          pop_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   count_o;
  logic          overflow_o;
  logic          underflow_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_q [$];

  queue_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_i),
    .pop_i      (pop_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every presented word against the scoreboard.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_valid: got data 0x%0h, expected no output", data_o);
      end else begin
        check("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Status vector {valid, overflow, underflow, full, empty, count}
  function automatic logic [8:0] status(input logic v, input logic o, input logic u,
                                        input int cnt);
    logic [AW:0] c;
    c = (AW+1)'(cnt);
    return {v, o, u, (cnt == DEPTH), (cnt == 0), c};
  endfunction

  // One clock of stimulus, then check the flags/count seen after the edge.
  task automatic op(input string name, input logic push, input logic pop,
                    input logic [DW-1:0] din, input logic exp_valid,
                    input logic exp_ovf, input logic exp_udf, input int exp_cnt,
                    input logic [DW-1:0] exp_data);
    push_i = push;
    pop_i  = pop;
    data_i = din;
    if (exp_valid) exp_q.push_back(exp_data);
    @(posedge clk_i);
    #1;
    push_i = 1'b0;
    pop_i  = 1'b0;
    check(name, 32'({valid_o, overflow_o, underflow_o, full_o, empty_o, count_o}),
          32'(status(exp_valid, exp_ovf, exp_udf, exp_cnt)));
  endtask

  task automatic push(input logic [DW-1:0] d, input int exp_cnt);
    op("push", 1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, exp_cnt, '0);
  endtask

  task automatic pop(input logic [DW-1:0] exp_d, input int exp_cnt);
    op("pop", 1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0, exp_cnt, exp_d);
  endtask

  task automatic do_reset(input logic push, input logic pop);
    rst_i  = 1'b1;
    push_i = push;
    pop_i  = pop;
    data_i = 8'hEE;
    @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    push_i = 1'b0;
    pop_i  = 1'b0;
    check("reset_status", 32'({valid_o, overflow_o, underflow_o, full_o, empty_o, count_o}),
          32'(status(1'b0, 1'b0, 1'b0, 0)));
    check("reset_data", 32'(data_o), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;

    // Reset, then fill 0x11..0x88
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      v = DW'(8'h11 * (i + 1));
      push(v, i + 1);
    end

    // Overflow: rejected push, one-cycle pulse, count held
    op("overflow", 1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 1'b0, 8, '0);
    op("overflow_clear", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 8, '0);

    // Drain in order, no 0x99
    for (int i = 0; i < DEPTH; i++) begin
      v = DW'(8'h11 * (i + 1));
      pop(v, DEPTH - 1 - i);
    end

    // Underflow: rejected pop, data_o holds last word
    op("underflow", 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, 0, '0);
    check("underflow_hold", 32'(data_o), 32'h88);
    op("underflow_clear", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 0, '0);

    // Wrap-around: advance pointers to 6, then 6 more words crossing entry 7
    for (int i = 0; i < 6; i++) begin
      v = DW'(i + 1);
      push(v, i + 1);
    end
    for (int i = 0; i < 6; i++) begin
      v = DW'(i + 1);
      pop(v, 5 - i);
    end
    for (int i = 0; i < 6; i++) begin
      v = DW'(8'hA0 + i);
      push(v, i + 1);
    end
    for (int i = 0; i < 6; i++) begin
      v = DW'(8'hA0 + i);
      pop(v, 5 - i);
    end

    // Simultaneous push+pop on empty: push wins, pop rejected
    op("sim_empty", 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1, '0);
    pop(8'h5A, 0);

    // Simultaneous push+pop on full: both accepted, old head returned
    for (int i = 0; i < DEPTH; i++) begin
      v = DW'(8'h11 * (i + 1));
      push(v, i + 1);
    end
    op("sim_full", 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 8, 8'h11);
    for (int i = 1; i < DEPTH; i++) begin
      v = DW'(8'h11 * (i + 1));
      pop(v, DEPTH - i);
    end
    pop(8'hC3, 0);

    // Reset mid-operation with push and pop asserted
    for (int i = 0; i < 5; i++) begin
      v = DW'(8'h31 + i);
      push(v, i + 1);
    end
    do_reset(1'b1, 1'b1);
    push(8'h7E, 1);
    pop(8'h7E, 0);

    // Every expected word must have been presented
    @(negedge clk_i);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
